// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit -- iterative RV32M multiply/divide execution unit.
//
// Sits behind the register file read ports. It takes both operands and the
// destination address of an M-extension instruction, iterates one bit per
// cycle, and hands the result to the register file write port.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   Start_MD      accept a new operation (IDLE only)
//   Kill_MD       abort the in-flight operation (CALC/FIX), wins over Start
//   Funct3_MD     RV32M funct3 (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   A_MD, B_MD    rs1 / rs2 operands
//   Rd_MD         destination register address
//   Busy_MD       high while an operation is in CALC or FIX
//   Done_MD       one-cycle result-valid pulse
//   Result_MD     result word, held until the next accepted Start
//   WAddr_MD      latched destination address
//   WrEn_MD       Done_MD qualified by WAddr_MD != 0
//
// Optional build macro: MULDIV_EARLY_OUT_EN
//   Multiplies stop once no multiplier bits remain; divides skip the
//   leading zeros of the dividend magnitude. Results are unchanged, only
//   latency shrinks. Undefined: fixed 34-cycle latency.
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Start_MD,
    input  logic            Kill_MD,
    input  logic [2:0]      Funct3_MD,
    input  logic [XLEN-1:0] A_MD,
    input  logic [XLEN-1:0] B_MD,
    input  logic [4:0]      Rd_MD,
    output logic            Busy_MD,
    output logic            Done_MD,
    output logic [XLEN-1:0] Result_MD,
    output logic [4:0]      WAddr_MD,
    output logic            WrEn_MD
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          f3_q;
    logic                neg_q;     // result must be negated in FIX
    logic [2*XLEN-1:0]   mcand;     // multiplicand, shifted left each step
    logic [XLEN-1:0]     mplier;    // multiplier, shifted right each step
    logic [2*XLEN-1:0]   acc;       // 64-bit product register
    logic [XLEN-1:0]     quo;       // dividend shifting out / quotient in
    logic [XLEN-1:0]     rem;       // restored partial remainder
    logic [XLEN-1:0]     dvsr;

    // ---------------- operand decode at Start ----------------
    logic              sgn_a, sgn_b, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;
    logic [XLEN-1:0]   quo_init;
    logic [CNT_W-1:0]  cnt_init;

`ifdef MULDIV_EARLY_OUT_EN
    function automatic logic [CNT_W-1:0] lzc(input logic [XLEN-1:0] v);
        logic [CNT_W-1:0] n;
        logic             found;
        n     = '0;
        found = 1'b0;
        for (int i = XLEN-1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + CNT_W'(1);
            end
        end
        return n;
    endfunction

    logic [CNT_W-1:0] a_lz, dvd_skip;
`endif

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (Funct3_MD)
            3'b001, 3'b100, 3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; end
            3'b010:                 sgn_a = 1'b1;
            default: ;
        endcase
        a_neg = sgn_a & A_MD[XLEN-1];
        b_neg = sgn_b & B_MD[XLEN-1];
        a_mag = a_neg ? -A_MD : A_MD;
        b_mag = b_neg ? -B_MD : B_MD;
        // remainder follows the dividend; quotient and product use the XOR
        neg_in = (Funct3_MD == 3'b110) ? a_neg : (a_neg ^ b_neg);

        div_zero = Funct3_MD[2] && (B_MD == '0);
        div_ovf  = Funct3_MD[2] && !Funct3_MD[0] &&
                   (A_MD == MIN_NEG) && (B_MD == '1);
        special  = div_zero | div_ovf;
        if (div_zero) special_res = Funct3_MD[1] ? A_MD : '1;
        else          special_res = Funct3_MD[1] ? '0   : MIN_NEG;

`ifdef MULDIV_EARLY_OUT_EN
        // leading zeros of the dividend contribute nothing; pre-shift them
        // out, but always keep at least one iteration
        a_lz     = lzc(a_mag);
        dvd_skip = (a_lz == CNT_W'(XLEN)) ? CNT_W'(XLEN-1) : a_lz;
        quo_init = a_mag << dvd_skip;
        cnt_init = Funct3_MD[2] ? (CNT_W'(XLEN) - dvd_skip) : CNT_W'(XLEN);
`else
        quo_init = a_mag;
        cnt_init = CNT_W'(XLEN);
`endif
    end

    // ---------------- one iteration ----------------
    logic [XLEN:0]     part;        // 33-bit partial remainder after shift
    logic              fits;
    logic              mul_last;

    always_comb begin
        part = {rem, quo[XLEN-1]};
        fits = (part >= {1'b0, dvsr});
`ifdef MULDIV_EARLY_OUT_EN
        mul_last = (mplier[XLEN-1:1] == '0);
`else
        mul_last = 1'b0;
`endif
    end

    // ---------------- sign fix / word select ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, fix_res;

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -quo : quo;
        r_fix    = neg_q ? -rem : rem;
        if (f3_q[2])              fix_res = f3_q[1] ? r_fix : q_fix;
        else if (f3_q[1:0] == 2'b00) fix_res = prod_fix[XLEN-1:0];
        else                      fix_res = prod_fix[2*XLEN-1:XLEN];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            quo       <= '0;
            rem       <= '0;
            dvsr      <= '0;
            Busy_MD   <= 1'b0;
            Done_MD   <= 1'b0;
            Result_MD <= '0;
            WAddr_MD  <= '0;
            WrEn_MD   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done_MD <= 1'b0;
                    WrEn_MD <= 1'b0;
                    if (Start_MD && !Kill_MD) begin
                        f3_q     <= Funct3_MD;
                        neg_q    <= neg_in;
                        WAddr_MD <= Rd_MD;
                        mcand    <= {{XLEN{1'b0}}, a_mag};
                        mplier   <= b_mag;
                        acc      <= '0;
                        quo      <= quo_init;
                        rem      <= '0;
                        dvsr     <= b_mag;
                        if (special) begin
                            Result_MD <= special_res;
                            Done_MD   <= 1'b1;
                            WrEn_MD   <= (Rd_MD != '0);
                            state     <= DONE;
                        end else begin
                            cnt     <= cnt_init;
                            Busy_MD <= 1'b1;
                            state   <= CALC;
                        end
                    end
                end

                CALC: begin
                    if (Kill_MD) begin
                        Busy_MD <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        if (f3_q[2]) begin
                            // restoring step: subtract only if it fits
                            rem <= fits ? XLEN'(part - {1'b0, dvsr})
                                        : part[XLEN-1:0];
                            quo <= {quo[XLEN-2:0], fits};
                        end else begin
                            if (mplier[0]) acc <= acc + mcand;
                            mcand  <= mcand << 1;
                            mplier <= mplier >> 1;
                        end
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1) || (!f3_q[2] && mul_last))
                            state <= FIX;
                    end
                end

                FIX: begin
                    Busy_MD <= 1'b0;
                    if (Kill_MD) begin
                        state <= IDLE;
                    end else begin
                        Result_MD <= fix_res;
                        Done_MD   <= 1'b1;
                        WrEn_MD   <= (WAddr_MD != '0);
                        state     <= DONE;
                    end
                end

                DONE: begin
                    Done_MD <= 1'b0;
                    WrEn_MD <= 1'b0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit -- directed scoreboard bench for muldiv_unit.
// Stimulus pushes hand-computed expectations; a negedge monitor pops one
// per Done pulse and compares result, write address, write enable and
// the cycle on which Done arrived.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, kill;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        busy, done, wren;
    logic [31:0] result;
    logic [4:0]  waddr;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .Start_MD(start), .Kill_MD(kill),
        .Funct3_MD(f3), .A_MD(a), .B_MD(b), .Rd_MD(rd),
        .Busy_MD(busy), .Done_MD(done), .Result_MD(result),
        .WAddr_MD(waddr), .WrEn_MD(wren)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [4:0]  wa;
        logic        we;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor: one scoreboard entry per Done pulse
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=%h expected=none (cycle %0d)", result, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_result"}, result, mon_e.res);
                chk({mon_e.name, "_waddr"}, 32'(waddr), 32'(mon_e.wa));
                chk({mon_e.name, "_wren"}, 32'(wren), 32'(mon_e.we));
`ifndef MULDIV_EARLY_OUT_EN
                chk({mon_e.name, "_done_cycle"}, 32'(cyc), 32'(mon_e.due));
`endif
            end
        end
    end

    task automatic wait_cyc(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // drive one Start for a cycle; optionally record the expected response
    task automatic issue(string nm, logic [2:0] fv, logic [31:0] av, logic [31:0] bv,
                         logic [4:0] r, logic [31:0] res, int lat, bit expect_done);
        exp_t e;
        f3 = fv; a = av; b = bv; rd = r; start = 1'b1;
        if (expect_done) begin
            e.name = nm; e.res = res; e.wa = r; e.we = (r != 5'd0); e.due = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(string nm);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d_pending expected=0", nm, sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, "_busy"},   32'(busy),   32'd0);
        chk({nm, "_done"},   32'(done),   32'd0);
        chk({nm, "_result"}, result,      32'd0);
        chk({nm, "_waddr"},  32'(waddr),  32'd0);
        chk({nm, "_wren"},   32'(wren),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    int t0;

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0;
        f3 = '0; a = '0; b = '0; rd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // MUL 7 * -3 with busy profile
        t0 = cyc;
        issue("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 34, 1'b1);
        @(negedge clk);
        chk("mul_busy_c1", 32'(busy), 32'd1);
        wait_cyc(t0 + 33);
        @(negedge clk);
        chk("mul_busy_c33", 32'(busy), 32'd1);
        @(negedge clk);
        chk("mul_busy_c34", 32'(busy), 32'd0);
        drain("mul");

        issue("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 34, 1'b1);
        drain("mulh");
        issue("mulhu_rd0", 3'b011, 32'h8000_0000, 32'h8000_0000, 5'd0, 32'h4000_0000, 34, 1'b1);
        drain("mulhu_rd0");
        issue("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 34, 1'b1);
        drain("mulhsu");
        issue("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 34, 1'b1);
        drain("div");
        issue("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 34, 1'b1);
        drain("rem");

        // DIVU with a Start re-asserted mid-flight and inputs scrambled
        t0 = cyc;
        issue("divu",   3'b101, 32'd100, 32'd7, 5'd12, 32'd14, 34, 1'b1);
        wait_cyc(t0 + 5);
        f3 = 3'b000; a = 32'd5; b = 32'd5; rd = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1;
        drain("divu");

        issue("remu",   3'b111, 32'd100, 32'd7, 5'd13, 32'd2, 34, 1'b1);
        drain("remu");

        // special cases complete on the cycle after Start
        issue("div_by0",  3'b100, 32'h1234_5678, 32'd0, 5'd14, 32'hFFFF_FFFF, 1, 1'b1);
        drain("div_by0");
        issue("remu_by0", 3'b111, 32'h1234_5678, 32'd0, 5'd15, 32'h1234_5678, 1, 1'b1);
        drain("remu_by0");
        issue("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, 1'b1);
        drain("div_ovf");

        // kill in CALC: no Done, busy drops next cycle, result retained
        t0 = cyc;
        issue("divu_kill", 3'b101, 32'd1000, 32'd3, 5'd4, 32'd0, 34, 1'b0);
        wait_cyc(t0 + 10);
        kill = 1'b1;
        @(negedge clk);
        chk("kill_busy_c10", 32'(busy), 32'd1);
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_busy_c11", 32'(busy), 32'd0);
        chk("kill_result_kept", result, 32'h8000_0000);
        repeat (40) @(posedge clk);
        #1;

        // reset mid-operation
        t0 = cyc;
        issue("mulhu_rst", 3'b011, 32'h0000_FFFF, 32'h0000_FFFF, 5'd6, 32'd0, 34, 1'b0);
        wait_cyc(t0 + 20);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midop_reset");
        repeat (40) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
